// File: rtl/motor_pkg.sv
// Shared types and constants for the motor duty ramp and its pwm neighbour.
package motor_pkg;

    localparam int unsigned PWM_MAX = 320;
    localparam int unsigned DUTY_W  = $clog2(PWM_MAX);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RAMP_DOWN = 3'd2,
        HOLD      = 3'd3,
        ESTOP     = 3'd4
    } motor_state_t;

endpackage

// File: rtl/motor_duty_ramp_if.sv
// Command/status bundle between the control logic and the duty ramp.
interface motor_duty_ramp_if #(
    parameter int unsigned N = 9
);
    logic         ena;
    logic [N-1:0] target;
    logic         estop;
    logic [N-1:0] duty;
    logic         at_target;
    logic [2:0]   state;

    modport master (
        output ena, target, estop,
        input  duty, at_target, state
    );

    modport slave (
        input  ena, target, estop,
        output duty, at_target, state
    );
endinterface

// File: rtl/tick_divider.sv
// Free-running prescaler: one-cycle tick on every TICKS-cycle wrap, clearable.
module tick_divider #(
    parameter int unsigned TICKS = 6000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Count up and wrap; clear holds the count at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/motor_duty_ramp.sv
// Slew-rate-limited duty generator with emergency stop, feeding the pwm block.
// Optional kick-start on leaving IDLE is enabled by defining MOTOR_KICKSTART_EN.
module motor_duty_ramp #(
    parameter int unsigned N              = motor_pkg::DUTY_W,
    parameter int unsigned PWM_MAX        = motor_pkg::PWM_MAX,
    parameter int unsigned TICKS_PER_STEP = 6000,
    parameter int unsigned STEP_SIZE      = 4,
    parameter int unsigned KICK_DUTY      = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    motor_duty_ramp_if.slave         bus
);
    import motor_pkg::*;

    localparam int unsigned   NW     = N + 1;
    localparam logic [N-1:0]  MAX_N  = N'(PWM_MAX);
    localparam logic [N-1:0]  STEP_N = N'(STEP_SIZE);
    localparam logic [N-1:0]  KICK_N = N'(KICK_DUTY);
`ifdef MOTOR_KICKSTART_EN
    localparam bit            KICK_EN = 1'b1;
`else
    localparam bit            KICK_EN = 1'b0;
`endif

    motor_state_t   state_q, state_d;
    logic [N-1:0]   duty_q, duty_d;
    logic           at_tgt_q;
    logic [N-1:0]   tgt_c, up_c, dn_c, kick_c;
    logic [NW-1:0]  sum_c;
    logic           step_tick;
    logic           div_clr;

    // Prescaler stays cleared while stopped so the first step is a full period away.
    assign div_clr = (state_q == IDLE) || (state_q == ESTOP);

    tick_divider #(.TICKS(TICKS_PER_STEP)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (step_tick)
    );

    // Effective target plus the candidate up/down/kick duty values.
    always_comb begin
        tgt_c = '0;
        if (bus.ena) begin
            tgt_c = (bus.target > MAX_N) ? MAX_N : bus.target;
        end
        sum_c = {1'b0, duty_q} + NW'(STEP_SIZE);
        up_c  = (sum_c > {1'b0, tgt_c}) ? tgt_c : sum_c[N-1:0];
        if (up_c > MAX_N) begin
            up_c = MAX_N;
        end
        dn_c = (duty_q > STEP_N) ? (duty_q - STEP_N) : '0;
        if (dn_c < tgt_c) begin
            dn_c = tgt_c;
        end
        kick_c = (KICK_N < tgt_c) ? KICK_N : tgt_c;
    end

    // Next-state and next-duty; estop overrides everything and drops any pending step.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (bus.estop) begin
            state_d = ESTOP;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (tgt_c != '0) begin
                        state_d = RAMP_UP;
                        if (KICK_EN) begin
                            duty_d = kick_c;
                        end
                    end
                end
                RAMP_UP: begin
                    if (duty_q == tgt_c) begin
                        state_d = (tgt_c == '0) ? IDLE : HOLD;
                    end else if (tgt_c < duty_q) begin
                        state_d = RAMP_DOWN;
                    end else if (step_tick) begin
                        duty_d = up_c;
                    end
                end
                RAMP_DOWN: begin
                    if (duty_q == tgt_c) begin
                        state_d = (tgt_c == '0) ? IDLE : HOLD;
                    end else if (tgt_c > duty_q) begin
                        state_d = RAMP_UP;
                    end else if (step_tick) begin
                        duty_d = dn_c;
                    end
                end
                HOLD: begin
                    if (tgt_c > duty_q) begin
                        state_d = RAMP_UP;
                    end else if (tgt_c < duty_q) begin
                        state_d = RAMP_DOWN;
                    end
                end
                ESTOP: begin
                    duty_d = '0;
                    if (tgt_c == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // State, duty and at_target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            at_tgt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            at_tgt_q <= (state_d != ESTOP) && (duty_q == tgt_c);
        end
    end

    assign bus.duty      = duty_q;
    assign bus.at_target = at_tgt_q;
    assign bus.state     = 3'(state_q);
endmodule

// File: tb/tb_motor_duty_ramp.sv
// Directed bench for motor_duty_ramp with TICKS_PER_STEP=4, STEP_SIZE=4.
module tb_motor_duty_ramp;
    import motor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_UP    = 3'(RAMP_UP);
    localparam logic [2:0] S_DOWN  = 3'(RAMP_DOWN);
    localparam logic [2:0] S_HOLD  = 3'(HOLD);
    localparam logic [2:0] S_ESTOP = 3'(ESTOP);

    motor_duty_ramp_if #(.N(9)) bus ();

    motor_duty_ramp #(
        .N(9), .PWM_MAX(320), .TICKS_PER_STEP(4), .STEP_SIZE(4), .KICK_DUTY(96)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.ena = 1'b1; bus.estop = 1'b0; bus.target = 9'd0;
        wait_n(2);
        rst = 1'b0;
        wait_n(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ena = 1'b1; bus.estop = 1'b0; bus.target = 9'd200;
        wait_n(3);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL reset_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, S_IDLE); end
        checks++; if (bus.at_target !== 1'b0) begin errors++; $display("FAIL reset_at_target got=%0b exp=0", bus.at_target); end
        rst = 1'b0;
        wait_n(4);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL reset_early_step got=%0d exp=0", bus.duty); end
        wait_n(1);
        checks++; if (bus.duty !== 9'd4) begin errors++; $display("FAIL reset_first_step got=%0d exp=4", bus.duty); end
        checks++; if (bus.state !== S_UP) begin errors++; $display("FAIL reset_ramp_state got=%0d exp=%0d", bus.state, S_UP); end
    endtask

    task automatic test_ramp_up();
        do_reset();
        bus.target = 9'd20;
        wait_n(4);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL ramp_pre got=%0d exp=0", bus.duty); end
        wait_n(1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) wait_n(4);
            checks++;
            if (bus.duty !== 9'(4 * k)) begin errors++; $display("FAIL ramp_step%0d got=%0d exp=%0d", k, bus.duty, 4 * k); end
        end
        checks++; if (bus.at_target !== 1'b0) begin errors++; $display("FAIL ramp_at_target_early got=%0b exp=0", bus.at_target); end
        wait_n(1);
        checks++; if (bus.state !== S_HOLD) begin errors++; $display("FAIL ramp_hold got=%0d exp=%0d", bus.state, S_HOLD); end
        checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL ramp_at_target got=%0b exp=1", bus.at_target); end
        wait_n(8);
        checks++; if (bus.duty !== 9'd20) begin errors++; $display("FAIL ramp_hold_duty got=%0d exp=20", bus.duty); end
    endtask

    task automatic test_clamp();
        int unsigned maxd = 0;
        do_reset();
        bus.target = 9'h1FF;
        for (int w = 1; w <= 340; w++) begin
            wait_n(1);
            if (32'(bus.duty) > maxd) maxd = 32'(bus.duty);
            if (w == 317) begin
                checks++; if (bus.duty !== 9'd316) begin errors++; $display("FAIL clamp_316 got=%0d exp=316", bus.duty); end
            end
            if (w == 321) begin
                checks++; if (bus.duty !== 9'd320) begin errors++; $display("FAIL clamp_320 got=%0d exp=320", bus.duty); end
            end
        end
        checks++; if (maxd != 320) begin errors++; $display("FAIL clamp_max got=%0d exp=320", maxd); end
        checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL clamp_at_target got=%0b exp=1", bus.at_target); end
        checks++; if (bus.state !== S_HOLD) begin errors++; $display("FAIL clamp_state got=%0d exp=%0d", bus.state, S_HOLD); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.target = 9'd100;
        wait_n(30);
        checks++; if (bus.duty !== 9'd28) begin errors++; $display("FAIL mid_pre got=%0d exp=28", bus.duty); end
        rst = 1'b1;
        wait_n(1);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL mid_rst_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL mid_rst_state got=%0d exp=%0d", bus.state, S_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_reversal();
        int unsigned mn = 511;
        int unsigned mx = 0;
        do_reset();
        bus.target = 9'd40;
        wait_n(25);
        checks++; if (bus.duty !== 9'd24) begin errors++; $display("FAIL rev_peak got=%0d exp=24", bus.duty); end
        bus.target = 9'd8;
        for (int w = 1; w <= 20; w++) begin
            wait_n(1);
            if (32'(bus.duty) < mn) mn = 32'(bus.duty);
            if (32'(bus.duty) > mx) mx = 32'(bus.duty);
            if (w % 4 == 0 && w <= 16) begin
                checks++;
                if (bus.duty !== 9'(24 - w)) begin errors++; $display("FAIL rev_w%0d got=%0d exp=%0d", w, bus.duty, 24 - w); end
            end
        end
        checks++; if (mn != 8 || mx != 24) begin errors++; $display("FAIL rev_range got=%0d..%0d exp=8..24", mn, mx); end
        checks++; if (bus.state !== S_HOLD) begin errors++; $display("FAIL rev_hold got=%0d exp=%0d", bus.state, S_HOLD); end
    endtask

    task automatic test_estop();
        do_reset();
        bus.target = 9'd100;
        wait_n(101);
        checks++; if (bus.duty !== 9'd100) begin errors++; $display("FAIL estop_pre got=%0d exp=100", bus.duty); end
        bus.estop = 1'b1;
        wait_n(1);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL estop_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.state !== S_ESTOP) begin errors++; $display("FAIL estop_state got=%0d exp=%0d", bus.state, S_ESTOP); end
        checks++; if (bus.at_target !== 1'b0) begin errors++; $display("FAIL estop_at_target got=%0b exp=0", bus.at_target); end
        bus.estop = 1'b0;
        wait_n(5);
        checks++; if (bus.state !== S_ESTOP || bus.duty !== 9'd0) begin
            errors++; $display("FAIL estop_stale got_state=%0d got_duty=%0d exp=%0d/0", bus.state, bus.duty, S_ESTOP);
        end
        bus.target = 9'd0;
        wait_n(1);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL estop_rearm got=%0d exp=%0d", bus.state, S_IDLE); end
    endtask

    task automatic test_estop_collision();
        do_reset();
        bus.target = 9'd40;
        wait_n(8);
        checks++; if (bus.duty !== 9'd4) begin errors++; $display("FAIL coll_pre got=%0d exp=4", bus.duty); end
        bus.estop = 1'b1;
        wait_n(1);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL coll_duty got=%0d exp=0", bus.duty); end
        bus.estop = 1'b0;
        bus.target = 9'd0;
        wait_n(1);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL coll_idle got=%0d exp=%0d", bus.state, S_IDLE); end
        bus.target = 9'd12;
        wait_n(4);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL coll_restart_early got=%0d exp=0", bus.duty); end
        wait_n(1);
        checks++; if (bus.duty !== 9'd4) begin errors++; $display("FAIL coll_restart got=%0d exp=4", bus.duty); end
    endtask

    task automatic test_ena_off();
        do_reset();
        bus.target = 9'd8;
        wait_n(10);
        checks++; if (bus.state !== S_HOLD || bus.duty !== 9'd8) begin
            errors++; $display("FAIL ena_hold got_state=%0d got_duty=%0d exp=%0d/8", bus.state, bus.duty, S_HOLD);
        end
        bus.ena = 1'b0;
        wait_n(1);
        checks++; if (bus.state !== S_DOWN) begin errors++; $display("FAIL ena_down got=%0d exp=%0d", bus.state, S_DOWN); end
        wait_n(2);
        checks++; if (bus.duty !== 9'd4) begin errors++; $display("FAIL ena_step got=%0d exp=4", bus.duty); end
        wait_n(4);
        checks++; if (bus.duty !== 9'd0) begin errors++; $display("FAIL ena_zero got=%0d exp=0", bus.duty); end
        wait_n(1);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL ena_idle got=%0d exp=%0d", bus.state, S_IDLE); end
        bus.ena = 1'b1;
    endtask

`ifdef MOTOR_KICKSTART_EN
    task automatic test_kickstart();
        do_reset();
        bus.target = 9'd200;
        wait_n(1);
        checks++; if (bus.duty !== 9'd96) begin errors++; $display("FAIL kick_load got=%0d exp=96", bus.duty); end
        wait_n(4);
        checks++; if (bus.duty !== 9'd100) begin errors++; $display("FAIL kick_step got=%0d exp=100", bus.duty); end
        do_reset();
        bus.target = 9'd50;
        wait_n(1);
        checks++; if (bus.duty !== 9'd50) begin errors++; $display("FAIL kick_small got=%0d exp=50", bus.duty); end
        wait_n(1);
        checks++; if (bus.state !== S_HOLD) begin errors++; $display("FAIL kick_hold got=%0d exp=%0d", bus.state, S_HOLD); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.estop = 1'b0;
        bus.target = 9'd0;
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_clamp();
        test_reset_mid();
        test_reversal();
        test_estop();
        test_estop_collision();
        test_ena_off();
`ifdef MOTOR_KICKSTART_EN
        test_kickstart();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
